// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Mid-bit sampling, one-cycle valid and
//               framing-error strobes, stuck-low line recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [1:0]       r_sync;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_busy;
    logic             w_rx_s;

    assign w_rx_s     = r_sync[1];
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 4'd0;
            r_shift      <= 8'h00;
            r_sync       <= 2'b11;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], rx_in};
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 4'd0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        // A start bit that is high again at mid-bit was a glitch
                        if (!w_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 4'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == 4'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        // Leaving at the stop midpoint lets a zero-gap start edge be caught
                        if (w_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard bench for uart_rx: directed and random 8N1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int HALF    = CPB / 2;
    localparam int LATENCY = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] mon_data  = 8'h00;
    bit         prev_rst  = 1'b1;
    bit         saw_busy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    // Serialises one frame; the expected outcome comes straight from the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int extra_low);
        exp_t     e;
        bit [9:0] fr;
        fr    = {stop_ok, d, 1'b0};
        e.err = !stop_ok;
        e.cyc = cyc + 1 + LATENCY;
        if (stop_ok) last_good = d;
        e.data = last_good;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) check("busy_in_frame", busy, 1);
            rx_in = fr[i];
            repeat (CPB) tick();
        end
        if (!stop_ok) begin
            repeat (extra_low) tick();
            check("busy_wait_idle", busy, 1);
            rx_in = 1'b1;
        end
    endtask

    // Monitor: pops the scoreboard on each strobe and checks the held byte.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (data_valid && frame_err) begin
                tests++;
                fails++;
                $display("FAIL valid_err_same_cycle: valid=%0b err=%0b", data_valid, frame_err);
            end
            if (data_valid || frame_err) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b data=0x%0h", data_valid, frame_err, data_out);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_err", frame_err, e.err);
                    check("pulse_data_out", data_out, e.data);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end else if (!prev_rst) begin
                check("data_out_hold", data_out, mon_data);
            end
            if (busy) saw_busy = 1'b1;
        end
        mon_data = data_out;
        prev_rst = rst;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        bit         ok;
        bit [9:0]   fr;
        int         wait_cnt;

        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) tick();
        check("reset_data_out", data_out, 8'h00);
        check("reset_valid", data_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(5);

        // Single clean frame
        send_frame(8'hA5, 1'b1, 0);
        idle(10);

        // Zero-gap pair
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(10);

        // Glitch shorter than half a bit
        saw_busy = 1'b0;
        rx_in = 1'b0;
        repeat (5) tick();
        idle(30);
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_busy_after", busy, 0);
        check("glitch_data_out", data_out, last_good);

        // Bad stop bit, stuck-low line, then recovery
        send_frame(8'h3C, 1'b0, 40);
        idle(16);
        send_frame(8'h81, 1'b1, 0);
        idle(10);

        // Reset during data bit 4 of 0x5A
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_in = fr[i];
            repeat (CPB) tick();
        end
        rx_in = fr[5];
        repeat (HALF) tick();
        rst   = 1'b1;
        rx_in = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_data_out", data_out, 8'h00);
        check("midreset_valid", data_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_busy", busy, 0);
        last_good = 8'h00;
        idle(20);
        send_frame(8'h5A, 1'b1, 0);
        idle(10);

        // Transmitter-style loopback burst, back to back
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h80, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hAA, 1'b1, 0);
        idle(10);

        // Random frames, occasional framing errors and random gaps
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, ok ? 0 : int'($urandom_range(0, 40)));
            idle(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12)));
        end
        idle(20);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 400) begin
            tick();
            wait_cnt++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("final_data_out", data_out, last_good);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
